// File: rtl/trivium_stream_cipher.sv
// Trivium stream cipher producing W keystream bits per clock; XORs them onto a valid/ready word stream.
// Latency: start -> INIT for INIT_ROUNDS/W cycles -> RUN; input word fire -> out_valid one cycle later.
// Backpressure: single output register, in_ready = !out_valid | out_ready; keystream advances only on input fire.
module trivium_stream_cipher #(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [79:0]      key,
    input  logic [79:0]      iv,
    input  logic             start,
    output logic             busy,
    output logic             ready_ks,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t         state_q;
    state_t         state_d;
    logic [287:0]   st_q;      // s(i) lives in st_q[i-1]
    logic [287:0]   st_adv;    // state after W rounds
    logic [W-1:0]   ks;        // keystream for this advance, LSB earliest
    logic [31:0]    rnd_cnt_q;
    logic           in_fire;
    logic           out_fire;
    logic           init_done;

    assign busy      = (state_q == INIT);
    assign ready_ks  = (state_q == RUN);
    assign in_ready  = (state_q == RUN) && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign init_done = (rnd_cnt_q + 32'(W)) == 32'(INIT_ROUNDS);

    // Unrolled W Trivium rounds; round k yields keystream bit k.
    always_comb begin
        logic t1, t2, t3;
        st_adv = st_q;
        ks     = '0;
        t1     = 1'b0;
        t2     = 1'b0;
        t3     = 1'b0;
        for (int k = 0; k < W; k++) begin
            t1    = st_adv[65]  ^ st_adv[92];
            t2    = st_adv[161] ^ st_adv[176];
            t3    = st_adv[242] ^ st_adv[287];
            ks[k] = t1 ^ t2 ^ t3;
            t1    = t1 ^ (st_adv[90]  & st_adv[91])  ^ st_adv[170];
            t2    = t2 ^ (st_adv[174] & st_adv[175]) ^ st_adv[263];
            t3    = t3 ^ (st_adv[285] & st_adv[286]) ^ st_adv[68];
            st_adv = {st_adv[286:177], t2, st_adv[175:93], t1, st_adv[91:0], t3};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start wins from any state; INIT hands over to RUN after the last warm-up advance.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = INIT;
        end else begin
            case (state_q)
                INIT:    if (init_done) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // Cipher state, warm-up counter, output register and word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= '0;
            rnd_cnt_q <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            word_cnt  <= '0;
        end else if (start) begin
            st_q      <= {3'b111, 112'b0, iv, 13'b0, key};
            rnd_cnt_q <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state_q == INIT) begin
                st_q      <= st_adv;
                rnd_cnt_q <= rnd_cnt_q + 32'(W);
            end
            if (in_fire) begin
                st_q      <= st_adv;
                out_data  <= in_data ^ ks;
                out_valid <= 1'b1;
                word_cnt  <= word_cnt + CNT_W'(1);
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_cipher.sv
// Bench for trivium_stream_cipher: W=8 main unit, a CNT_W=4 twin on the same inputs, W=1 and W=64 units.
// Expected keystream comes from a bit-array Trivium model; a queue scoreboard tracks in-flight words.
// Covers reset, golden run, round trip, backpressure, restart, async reset and counter wrap.
module tb_trivium_stream_cipher;

    localparam int NKS = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [79:0] key, iv;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        a_busy, a_ready_ks, a_in_ready, a_out_valid;
    logic [7:0]  a_out_data;
    logic [31:0] a_word_cnt;
    logic        d_busy, d_ready_ks, d_in_ready, d_out_valid;
    logic [7:0]  d_out_data;
    logic [3:0]  d_word_cnt;

    logic [79:0] key_bc, iv_bc;
    logic        start_bc;
    logic        bc_valid = 1'b1;
    logic        bc_ready = 1'b1;
    logic        b_in_data = 1'b0;
    logic [63:0] c_in_data = 64'd0;
    logic        b_busy, b_ready_ks, b_in_ready, b_out_valid, b_out_data;
    logic [31:0] b_word_cnt;
    logic        c_busy, c_ready_ks, c_in_ready, c_out_valid;
    logic [63:0] c_out_data;
    logic [31:0] c_word_cnt;

    trivium_stream_cipher #(.W(8), .INIT_ROUNDS(1152), .CNT_W(32)) u_a (
        .clk(clk), .reset(reset), .key(key), .iv(iv), .start(start), .busy(a_busy),
        .ready_ks(a_ready_ks), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .word_cnt(a_word_cnt));

    trivium_stream_cipher #(.W(8), .INIT_ROUNDS(1152), .CNT_W(4)) u_d (
        .clk(clk), .reset(reset), .key(key), .iv(iv), .start(start), .busy(d_busy),
        .ready_ks(d_ready_ks), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .word_cnt(d_word_cnt));

    trivium_stream_cipher #(.W(1), .INIT_ROUNDS(1152), .CNT_W(32)) u_b (
        .clk(clk), .reset(reset), .key(key_bc), .iv(iv_bc), .start(start_bc), .busy(b_busy),
        .ready_ks(b_ready_ks), .in_valid(bc_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(bc_ready), .out_data(b_out_data), .word_cnt(b_word_cnt));

    trivium_stream_cipher #(.W(64), .INIT_ROUNDS(1152), .CNT_W(32)) u_c (
        .clk(clk), .reset(reset), .key(key_bc), .iv(iv_bc), .start(start_bc), .busy(c_busy),
        .ready_ks(c_ready_ks), .in_valid(bc_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(bc_ready), .out_data(c_out_data), .word_cnt(c_word_cnt));

    int         n_chk = 0;
    int         n_err = 0;
    bit         ks_bits [0:NKS-1];
    logic [7:0] exp_q[$];
    logic [7:0] out_q[$];
    int         ki;
    int         acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference Trivium over a 1-indexed bit array, straight from the round equations.
    task automatic gen_ks(input logic [79:0] k, input logic [79:0] v);
        bit s [1:288];
        bit t1, t2, t3, z;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[93 + i] = v[i-1];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < 1152 + NKS; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 93; i >= 2; i--)   s[i] = s[i-1];
            s[1] = t3;
            for (int i = 177; i >= 95; i--) s[i] = s[i-1];
            s[94] = t1;
            for (int i = 288; i >= 179; i--) s[i] = s[i-1];
            s[178] = t2;
            if (r >= 1152) ks_bits[r-1152] = z;
        end
    endtask

    function automatic logic [7:0] ks_word(input int idx);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = ks_bits[8*idx + i];
        return w;
    endfunction

    // One cycle on the W=8 units: drive inputs at negedge, then score what fires at the next posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic ordy);
        logic [7:0] e;
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = ordy;
        #1;
        if (a_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(a_out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(a_out_data), 64'(e));
                chk("cnt4_out_data", 64'(d_out_data), 64'(e));
                out_q.push_back(a_out_data);
            end
        end
        if (in_valid && a_in_ready) begin
            exp_q.push_back(d ^ ks_word(ki));
            ki++;
            acc++;
        end
    endtask

    task automatic start_a(input logic [79:0] k, input logic [79:0] v);
        @(negedge clk);
        key = k; iv = v; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; key = ~k; iv = ~v;
        #1;
        exp_q.delete(); out_q.delete(); ki = 0; acc = 0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (a_busy && n < 2000) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 8'h00, 1'b1);
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic stream_zeros(input int nwords);
        int guard = 0;
        while (acc < nwords && guard < 400) begin
            guard++;
            step(1'b1, 8'h00, 1'b1);
        end
        chk("stream_timeout", 64'(acc), 64'(nwords));
        drain();
    endtask

    logic [79:0]  rk, rv, ke, ve;
    logic [95:0]  r96;
    logic [7:0]   pt [0:31];
    logic [7:0]   ct [0:31];
    logic [7:0]   held;
    logic [255:0] bbits, cbits, mbits;
    int           n, guard, nb, nc, bb, cb, cyc;
    bit           stalled;

    initial begin
        reset = 1'b0; key = '0; iv = '0; start = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        key_bc = '0; iv_bc = '0; start_bc = 1'b0;

        // Reset values
        @(negedge clk); #1;
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_ready_ks", 64'(a_ready_ks), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data", 64'(a_out_data), 64'd0);
        chk("rst_word_cnt", 64'(a_word_cnt), 64'd0);
        @(negedge clk); reset = 1'b1;

        // Golden run, key=0 iv=0; 17 words also wraps the CNT_W=4 counter to 1
        gen_ks(80'd0, 80'd0);
        start_a(80'd0, 80'd0);
        wait_init(n);
        chk("init_cycles_w8", 64'(n), 64'd144);
        chk("ready_ks_run", 64'(a_ready_ks), 64'd1);
        stream_zeros(17);
        chk("golden_word_cnt", 64'(a_word_cnt), 64'd17);
        chk("wrap_word_cnt4", 64'(d_word_cnt), 64'd1);

        // Restart mid-RUN with a word pending
        step(1'b1, 8'h5a, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        chk("pre_restart_out_valid", 64'(a_out_valid), 64'd1);
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart_out_valid", 64'(a_out_valid), 64'd0);
        chk("restart_busy", 64'(a_busy), 64'd1);
        chk("restart_word_cnt", 64'(a_word_cnt), 64'd0);
        chk("restart_word_cnt4", 64'(d_word_cnt), 64'd0);
        exp_q.delete();

        // Asynchronous reset mid-INIT
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_busy", 64'(a_busy), 64'd0);
        chk("arst_ready_ks", 64'(a_ready_ks), 64'd0);
        chk("arst_out_valid", 64'(a_out_valid), 64'd0);
        chk("arst_out_data", 64'(a_out_data), 64'd0);
        chk("arst_word_cnt", 64'(a_word_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("idle_busy", 64'(a_busy), 64'd0);
        chk("idle_ready_ks", 64'(a_ready_ks), 64'd0);
        chk("idle_in_ready", 64'(a_in_ready), 64'd0);
        in_valid = 1'b0;

        // Round trip with random key/iv and a 5-cycle output stall
        r96 = {$urandom(), $urandom(), $urandom()}; rk = r96[79:0];
        r96 = {$urandom(), $urandom(), $urandom()}; rv = r96[79:0];
        for (int i = 0; i < 32; i++) pt[i] = 8'($urandom_range(0, 255));
        gen_ks(rk, rv);
        start_a(rk, rv);
        wait_init(n);
        chk("init_cycles_rt", 64'(n), 64'd144);
        guard = 0; stalled = 1'b0;
        while (acc < 32 && guard < 400) begin
            guard++;
            if (acc == 10 && !stalled) begin
                stalled = 1'b1;
                step(1'b1, pt[acc], 1'b0);
                held = a_out_data;
                chk("bp_in_ready_first", 64'(a_in_ready), 64'd0);
                for (int s = 0; s < 4; s++) begin
                    step(1'b1, pt[acc], 1'b0);
                    chk("bp_hold_data", 64'(a_out_data), 64'(held));
                    chk("bp_out_valid", 64'(a_out_valid), 64'd1);
                    chk("bp_in_ready", 64'(a_in_ready), 64'd0);
                end
            end else begin
                step(1'b1, pt[acc], 1'b1);
            end
        end
        drain();
        chk("rt_enc_words", 64'(out_q.size()), 64'd32);
        chk("rt_enc_word_cnt", 64'(a_word_cnt), 64'd32);
        for (int i = 0; i < 32; i++) ct[i] = (i < out_q.size()) ? out_q[i] : 8'h00;
        start_a(rk, rv);
        wait_init(n);
        stream_zeros(0);
        guard = 0;
        while (acc < 32 && guard < 400) begin
            guard++;
            step(1'b1, ct[acc], 1'b1);
        end
        drain();
        chk("rt_dec_words", 64'(out_q.size()), 64'd32);
        for (int i = 0; i < 32 && i < out_q.size(); i++) chk("rt_plain", 64'(out_q[i]), 64'(pt[i]));
        chk("rt_word_cnt", 64'(a_word_cnt), 64'd32);

        // Width equivalence: W=8 (scoreboard), W=1 and W=64 against the same model stream
        ke = 80'h0123456789ABCDEF0123;
        ve = 80'hFEDCBA98765432100000;
        gen_ks(ke, ve);
        start_a(ke, ve);
        wait_init(n);
        stream_zeros(32);
        key_bc = ke; iv_bc = ve;
        @(negedge clk); start_bc = 1'b1;
        @(negedge clk); start_bc = 1'b0; key_bc = ~ke; iv_bc = ~ve;
        #1;
        nb = 0; nc = 0; bb = 0; cb = 0; cyc = 0;
        bbits = '0; cbits = '0;
        while (!(nb == 256 && nc == 4) && cyc < 3000) begin
            if (b_busy) bb++;
            if (c_busy) cb++;
            if (b_out_valid && nb < 256) begin bbits[nb] = b_out_data; nb++; end
            if (c_out_valid && nc < 4) begin cbits[nc*64 +: 64] = c_out_data; nc++; end
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("w1_init_cycles", 64'(bb), 64'd1152);
        chk("w64_init_cycles", 64'(cb), 64'd18);
        chk("w_collect_timeout", 64'(nb + nc), 64'd260);
        for (int i = 0; i < 256; i++) mbits[i] = ks_bits[i];
        for (int j = 0; j < 4; j++) begin
            chk("w1_stream", bbits[j*64 +: 64], mbits[j*64 +: 64]);
            chk("w64_stream", cbits[j*64 +: 64], mbits[j*64 +: 64]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/trivium_stream_cipher.md
Name: trivium_stream_cipher

Overview:
- Parametrised Trivium stream-cipher engine. Generalises the single-bit encryptor to W keystream bits per clock.
- Adds three capabilities: a programmable initialisation length, a start/busy control interface, and valid/ready data streaming that XORs input words with keystream.
- Sits between the key/IV configuration logic and the payload datapath. Encryption and decryption are the same operation.

Parameters:
- W, default 8: keystream bits produced per cycle. Legal values 1..64.
- INIT_ROUNDS, default 1152: warm-up rounds with output discarded. Must be a multiple of W.
- CNT_W, default 32: width of the processed-word counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- key  in  80  key; key[0] maps to state bit s1.
- iv  in  80  IV; iv[0] maps to state bit s94.
- start  in  1  pulse: load key/iv and begin initialisation.
- busy  out  1  high while in INIT.
- ready_ks  out  1  high while in RUN (keystream available).
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted this cycle when in_valid is also high.
- in_data  in  W  plaintext or ciphertext word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  W  in_data XOR keystream.
- word_cnt  out  CNT_W  words processed since the last start.

Behaviour:
- State s1..s288, held in reg[287:0] with s(i) = reg[i-1].
- Load on start:
  - s1..s80 = key, s81..s93 = 0.
  - s94..s173 = iv, s174..s285 = 0.
  - s286..s288 = 1.
- One Trivium round:
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288, z = t1^t2^t3.
  - t1 ^= s91&s92^s171; t2 ^= s175&s176^s264; t3 ^= s286&s287^s69.
  - Shift: s1..s93 <= {t3, s1..s92}; s94..s177 <= {t1, s94..s176}; s178..s288 <= {t2, s178..s287}.
- W rounds per advance, unrolled combinationally. Round k (k = 0..W-1) supplies keystream bit k: LSB carries the earliest bit.
- FSM states: IDLE, INIT, RUN.
- Reset values (reset low, asynchronous):
  - State IDLE, state register all 0, round counter 0.
  - out_valid = 0, out_data = 0, word_cnt = 0.
  - busy = 0, ready_ks = 0, in_ready = 0.
- IDLE: waits for start.
- start sampled high in any state takes priority over all other events:
  - load key/iv; round counter = 0; word_cnt = 0;
  - out_valid cleared (pending output is dropped); go to INIT.
- INIT:
  - advance W rounds per cycle, output discarded; counter += W.
  - When counter + W == INIT_ROUNDS, the next state is RUN.
  - INIT lasts exactly INIT_ROUNDS/W cycles.
  - busy = 1.
- RUN:
  - ready_ks = 1.
  - in_ready = !out_valid | out_ready (single output register; full throughput under no backpressure).
  - On in fire: out_data <= in_data ^ z[W-1:0]; out_valid <= 1; state register advances W rounds; word_cnt++.
  - The keystream advances only on in fire, never while stalled.
- Output register:
  - out_valid clears on out fire with no simultaneous in fire.
  - out_data and out_valid are held stable while out_valid=1 and out_ready=0.
- Latency: input fire to out_valid is 1 cycle.
- word_cnt wraps modulo 2^CNT_W with no flag.
- Outside RUN: in_ready = 0; in_valid is ignored.
- key and iv are sampled only in the start cycle.
- Reset asserted mid-INIT or mid-RUN returns the block to IDLE immediately. A new start is required before further operation.

Test Plan:
- Golden vector, W=8, key=0, iv=0, start pulse: busy stays high exactly 144 cycles. Stream 16 words of in_data=0; out_data matches the golden C model keystream bits 1..128, LSB-first.
- Width equivalence: configs W=1 (INIT 1152 cycles), W=8, and W=64 (INIT 18 cycles) with the same key=0x0123456789ABCDEF0123 and iv=0xFEDCBA98765432100000. The concatenated 256-bit outputs must be identical across all three.
- Round-trip: encrypt 32 random words, restart with the same key/iv, feed the ciphertext back in. Output equals the original plaintext bit-for-bit; word_cnt=32.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1.
  - Required: out_data is held; in_ready=0 after the first accepted word; no keystream bits are skipped.
  - After release, the stream continues identically to an unstalled run.
- Restart and reset:
  - start mid-RUN with out_valid=1: out_valid=0 next cycle, busy=1, word_cnt=0.
  - reset pulsed low mid-INIT: busy=0 and all outputs at reset values asynchronously; block stays in IDLE until start.
- Counter wrap, CNT_W=4: 17 words processed → word_cnt=1; data remains correct.
